csoc_scan_tester: RTL and testbench
===================================

CSOC_SCAN_TESTER -- requirements
Module: csoc_scan_tester

Interface
REQ-001 Parameter NREGS, default 1918: scan chain length in flops, minimum 2.
REQ-002 Parameter SEED_DEF, default 16'hACE1: seed substituted when seed_i is zero.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous and active-low.
REQ-005 start_i  input  1  starts one test when sampled high in IDLE.
REQ-006 abort_i  input  1  cancels the test in progress.
REQ-007 seed_i  input  16  LFSR seed, captured on accepted start.
REQ-008 scan_out_i  input  1  serial chain output from the DUT.
REQ-009 scan_in_o  output  1  serial chain input to the DUT.
REQ-010 test_se_o  output  1  scan enable to the DUT.
REQ-011 test_tm_o  output  1  test mode to the DUT.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 done_o  output  1  one-cycle pulse at test completion.
REQ-014 pass_o  output  1  result of the last completed test.
REQ-015 err_count_o  output  16  mismatch count of the last test.

Function
REQ-016 States: IDLE, LOAD, CAPTURE, UNLOAD, DONE.
REQ-017 IDLE -> LOAD on start_i=1: tx and rx LFSRs loaded with seed_i, or SEED_DEF if seed_i==0; bit counter=0; pass_o=0; err_count_o=0.
REQ-018 start_i is ignored outside IDLE.
REQ-019 LFSR: 16-bit Fibonacci, taps 16,14,13,11; shift right; new bit15 = b0^b2^b3^b5; serial bit = b0.
REQ-020 LOAD, NREGS cycles: test_se_o=1; scan_in_o=tx b0; tx advances each cycle; scan_out_i not compared.
REQ-021 LOAD -> CAPTURE when counter==NREGS-1; counter clears.
REQ-022 CAPTURE, exactly 1 cycle: test_se_o=0; scan_in_o=0; then UNLOAD.
REQ-023 UNLOAD, NREGS cycles: test_se_o=1; scan_in_o=0; scan_out_i compared with rx b0; rx advances each cycle.
REQ-024 Unload bit k shall equal load bit k, for k = 0..NREGS-1.
REQ-025 Any mismatch clears an internal sticky ok flag.
REQ-026 UNLOAD -> DONE after counter==NREGS-1, including its compare.
REQ-027 DONE, 1 cycle: done_o=1; pass_o=ok; then IDLE.
REQ-028 test_tm_o=1 in every state except IDLE.
REQ-029 Counter width: $clog2(NREGS); no wrap inside a phase.
REQ-030 abort_i=1 in any non-IDLE state -> IDLE on the next edge: test_se_o=0, pass_o=0, done_o not pulsed.
REQ-031 abort_i has priority over every other transition.
REQ-032 pass_o and err_count_o hold their values until the next accepted start.

Reset
REQ-033 rstn_i low forces IDLE and LFSRs=SEED_DEF.
REQ-034 Reset values: scan_in_o=0, test_se_o=0, test_tm_o=0, busy_o=0, done_o=0, pass_o=0, err_count_o=0.
REQ-035 Reset mid-test discards all progress; no done_o pulse.

Configuration
REQ-036 Macro CSOC_SCAN_ERRCNT_EN defined: err_count_o increments on each UNLOAD mismatch and saturates at 16'hFFFF.
REQ-037 Macro CSOC_SCAN_ERRCNT_EN absent: err_count_o is tied to 0 and only pass_o reports the result.

Verification
REQ-038 NREGS=8, ideal 8-flop shift chain, seed 16'h0001 -> done_o at cycle 18 after start; pass_o=1; err_count_o=0.
REQ-039 Same setup, chain flop 3 stuck-at-0 -> pass_o=0; err_count_o equals the count of 1-bits the stuck flop corrupts (macro on); err_count_o=0 (macro off).
REQ-040 seed_i=0 -> scan_in_o load stream equals the SEED_DEF sequence 1,0,0,0,0,1,1,1...
REQ-041 abort_i at LOAD cycle 4 -> IDLE next cycle; test_se_o=0; done_o never asserted; pass_o=0.
REQ-042 start_i held high for the whole test -> exactly one test runs; a second test starts on the cycle after DONE.
REQ-043 rstn_i low during UNLOAD -> all outputs at reset values immediately; fresh start then passes.

Source files
------------

// File: rtl/csoc_scan_tester.sv
// Scan-chain load/capture/unload tester driven by a 16-bit LFSR pattern.
// Optional mismatch counter: define CSOC_SCAN_ERRCNT_EN.
module csoc_scan_tester #(
    parameter int          NREGS    = 1918,
    parameter logic [15:0] SEED_DEF = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] seed_i,
    input  logic        scan_out_i,
    output logic        scan_in_o,
    output logic        test_se_o,
    output logic        test_tm_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_count_o
);

    localparam int CW = $clog2(NREGS);
    localparam logic [CW-1:0] LAST = CW'(NREGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        DONE
    } state_t;

    state_t        state;
    logic [15:0]   tx;
    logic [15:0]   rx;
    logic [CW-1:0] cnt;
    logic          ok;
    logic [15:0]   seed_sel;
    logic          mis;

`ifdef CSOC_SCAN_ERRCNT_EN
    logic [15:0]   err_q;
    assign err_count_o = err_q;
`else
    assign err_count_o = '0;
`endif

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    assign seed_sel = (seed_i == 16'h0000) ? SEED_DEF : seed_i;
    assign mis      = scan_out_i ^ rx[0];

    // Test sequencer: state, pattern generators and registered outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= IDLE;
            tx        <= SEED_DEF;
            rx        <= SEED_DEF;
            cnt       <= '0;
            ok        <= 1'b1;
            scan_in_o <= 1'b0;
            test_se_o <= 1'b0;
            test_tm_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            pass_o    <= 1'b0;
`ifdef CSOC_SCAN_ERRCNT_EN
            err_q     <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            if (state != IDLE && abort_i) begin
                state     <= IDLE;
                cnt       <= '0;
                scan_in_o <= 1'b0;
                test_se_o <= 1'b0;
                test_tm_o <= 1'b0;
                busy_o    <= 1'b0;
                pass_o    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_i) begin
                            state     <= LOAD;
                            tx        <= lfsr_next(seed_sel);
                            rx        <= seed_sel;
                            cnt       <= '0;
                            ok        <= 1'b1;
                            pass_o    <= 1'b0;
                            scan_in_o <= seed_sel[0];
                            test_se_o <= 1'b1;
                            test_tm_o <= 1'b1;
                            busy_o    <= 1'b1;
`ifdef CSOC_SCAN_ERRCNT_EN
                            err_q     <= '0;
`endif
                        end
                    end
                    LOAD: begin
                        if (cnt == LAST) begin
                            state     <= CAPTURE;
                            cnt       <= '0;
                            scan_in_o <= 1'b0;
                            test_se_o <= 1'b0;
                        end else begin
                            cnt       <= cnt + CW'(1);
                            scan_in_o <= tx[0];
                            tx        <= lfsr_next(tx);
                        end
                    end
                    CAPTURE: begin
                        state     <= UNLOAD;
                        test_se_o <= 1'b1;
                    end
                    UNLOAD: begin
                        rx <= lfsr_next(rx);
                        if (mis) begin
                            ok <= 1'b0;
                        end
`ifdef CSOC_SCAN_ERRCNT_EN
                        if (mis && err_q != 16'hFFFF) begin
                            err_q <= err_q + 16'd1;
                        end
`endif
                        if (cnt == LAST) begin
                            state     <= DONE;
                            cnt       <= '0;
                            test_se_o <= 1'b0;
                            done_o    <= 1'b1;
                            pass_o    <= ok & ~mis;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DONE: begin
                        state     <= IDLE;
                        test_tm_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csoc_scan_tester.sv
// Randomised bench for csoc_scan_tester with an 8-flop chain model
// and a cycle-indexed reference model of the test sequence.
module tb_csoc_scan_tester;

    localparam int          N  = 8;
    localparam logic [15:0] SD = 16'hACE1;

    logic        clk_i      = 1'b0;
    logic        rstn_i     = 1'b0;
    logic        start_i    = 1'b0;
    logic        abort_i    = 1'b0;
    logic [15:0] seed_i     = 16'h0000;
    logic        scan_out_i;
    logic        scan_in_o;
    logic        test_se_o;
    logic        test_tm_o;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic [15:0] err_count_o;

    int vectors     = 0;
    int miscompares = 0;

    csoc_scan_tester #(.NREGS(N), .SEED_DEF(SD)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .seed_i      (seed_i),
        .scan_out_i  (scan_out_i),
        .scan_in_o   (scan_in_o),
        .test_se_o   (test_se_o),
        .test_tm_o   (test_tm_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .err_count_o (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Device-under-test scan chain: ideal shift register, optional
    // stuck-at-0 on flop 3, optional output bit flip.
    logic [N-1:0] chain = '0;
    logic         stuck3 = 1'b0;
    logic         flip   = 1'b0;
    logic [N-1:0] chain_nxt;

    always_comb begin
        chain_nxt = {chain[N-2:0], scan_in_o};
        if (stuck3) chain_nxt[3] = 1'b0;
    end

    always @(posedge clk_i) begin
        if (test_se_o) chain <= chain_nxt;
    end

    assign scan_out_i = chain[N-1] ^ flip;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // k-th serial bit of the LFSR stream started from seed s
    function automatic logic lfsr_bit(input logic [15:0] s, input int k);
        logic [15:0] v;
        v = s;
        for (int i = 0; i < k; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
        return v[0];
    endfunction

    // Reference model: m_c is cycles since the accepted start edge.
    // LOAD 0..N-1, CAPTURE N, UNLOAD N+1..2N, DONE 2N+1.
    bit   m_act  = 1'b0;
    int   m_c    = 0;
    int   m_err  = 0;
    bit   m_pass = 1'b0;
    logic m_load [N];

    initial begin
        logic [15:0] s;
        logic        e_se;
        logic        e_si;
        logic [15:0] e_ec;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                m_act  = 1'b0;
                m_c    = 0;
                m_err  = 0;
                m_pass = 1'b0;
            end
            e_se = m_act && (m_c < N || (m_c >= N + 1 && m_c <= 2 * N));
            e_si = (m_act && m_c < N) ? m_load[m_c] : 1'b0;
`ifdef CSOC_SCAN_ERRCNT_EN
            e_ec = (m_err > 65535) ? 16'hFFFF : 16'(m_err);
`else
            e_ec = 16'h0000;
`endif
            chk1("busy", busy_o, m_act);
            chk1("tm", test_tm_o, m_act);
            chk1("se", test_se_o, e_se);
            chk1("scan_in", scan_in_o, e_si);
            chk1("done", done_o, m_act && m_c == 2 * N + 1);
            chk1("pass", pass_o, m_pass);
            chk16("err_count", err_count_o, e_ec);
            if (rstn_i) begin
                if (!m_act) begin
                    if (start_i) begin
                        s = (seed_i == 16'h0000) ? SD : seed_i;
                        for (int k = 0; k < N; k++) m_load[k] = lfsr_bit(s, k);
                        m_act  = 1'b1;
                        m_c    = 0;
                        m_err  = 0;
                        m_pass = 1'b0;
                    end
                end else if (abort_i) begin
                    m_act  = 1'b0;
                    m_pass = 1'b0;
                end else if (m_c == 2 * N + 1) begin
                    m_act = 1'b0;
                end else begin
                    if (m_c >= N + 1 && scan_out_i !== m_load[m_c - N - 1])
                        m_err++;
                    m_c++;
                    if (m_c == 2 * N + 1) m_pass = (m_err == 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One test from IDLE; reports done latency, result and load stream.
    task automatic run_test(input logic [15:0] seed, input logic st,
                            output int lat, output logic ps,
                            output logic [15:0] ec, output logic [N-1:0] strm);
        lat    = -1;
        ps     = 1'b0;
        ec     = 16'h0;
        strm   = '0;
        stuck3 = st;
        seed_i = seed;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (i < N) strm[i] = scan_in_o;
            if (done_o) begin
                lat = i;
                ps  = pass_o;
                ec  = err_count_o;
                break;
            end
        end
        chk1("done_seen", lat >= 0, 1'b1);
        tick();
        stuck3 = 1'b0;
    endtask

    initial begin
        int          lat;
        int          d1;
        int          d2;
        logic        ps;
        logic [15:0] ec;
        logic [N-1:0] strm;

        tick();
        tick();
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_se", test_se_o, 1'b0);
        chk16("rst_err", err_count_o, 16'h0000);
        rstn_i = 1'b1;
        tick();

        // The model's pattern rule pinned against hand-derived bits
        chk1("model_0001_b0", lfsr_bit(16'h0001, 0), 1'b1);
        chk1("model_0001_b1", lfsr_bit(16'h0001, 1), 1'b0);
        chk1("model_ace1_b5", lfsr_bit(SD, 5), 1'b1);

        // Ideal chain, seed 1: done in the 18th cycle (index 17)
        run_test(16'h0001, 1'b0, lat, ps, ec, strm);
        chk16("ideal_latency", 16'(lat), 16'd17);
        chk1("ideal_pass", ps, 1'b1);
        chk16("ideal_err", ec, 16'h0000);
        chk16("ideal_stream", 16'(strm), 16'h0001);

        // Flop 3 stuck-at-0 zeroes every bit; one 1-bit in the stream
        run_test(16'h0001, 1'b1, lat, ps, ec, strm);
        chk1("stuck_pass", ps, 1'b0);
`ifdef CSOC_SCAN_ERRCNT_EN
        chk16("stuck_err", ec, 16'd1);
`else
        chk16("stuck_err", ec, 16'd0);
`endif

        // Zero seed selects the default: 1,0,0,0,0,1,1,1
        run_test(16'h0000, 1'b0, lat, ps, ec, strm);
        chk16("default_stream", 16'(strm), 16'h00E1);
        chk1("default_pass", ps, 1'b1);

        // Abort in LOAD cycle 4
        seed_i  = 16'h1234;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk1("abort_busy", busy_o, 1'b0);
        chk1("abort_se", test_se_o, 1'b0);
        chk1("abort_pass", pass_o, 1'b0);
        d1 = 0;
        for (int i = 0; i < 2 * N + 4; i++) begin
            @(negedge clk_i);
            if (done_o) d1++;
        end
        chk16("abort_no_done", 16'(d1), 16'd0);
        tick();

        // Start held high: back-to-back tests, one IDLE cycle between
        seed_i  = 16'h0001;
        start_i = 1'b1;
        tick();
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                if (d1 < 0) d1 = i;
                else begin
                    d2 = i;
                    break;
                end
            end
        end
        tick();
        start_i = 1'b0;
        chk16("held_first", 16'(d1), 16'd17);
        chk16("held_gap", 16'(d2 - d1), 16'd19);
        repeat (3) tick();

        // Reset during UNLOAD
        seed_i  = 16'hBEEF;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (N + 3) tick();
        rstn_i = 1'b0;
        #1;
        chk1("mid_rst_si", scan_in_o, 1'b0);
        chk1("mid_rst_se", test_se_o, 1'b0);
        chk1("mid_rst_tm", test_tm_o, 1'b0);
        chk1("mid_rst_busy", busy_o, 1'b0);
        chk1("mid_rst_done", done_o, 1'b0);
        chk1("mid_rst_pass", pass_o, 1'b0);
        chk16("mid_rst_err", err_count_o, 16'h0000);
        tick();
        rstn_i = 1'b1;
        tick();
        run_test(16'hBEEF, 1'b0, lat, ps, ec, strm);
        chk1("post_rst_pass", ps, 1'b1);

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) stuck3 = ($urandom_range(0, 3) == 0);
            start_i = ($urandom_range(0, 3) == 0);
            abort_i = ($urandom_range(0, 60) == 0);
            flip    = ($urandom_range(0, 15) == 0);
            seed_i  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            rstn_i  = ($urandom_range(0, 400) != 0);
            tick();
        end
        rstn_i  = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        flip    = 1'b0;
        stuck3  = 1'b0;
        repeat (2 * N + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
